// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decoder handshake.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    // Memory / decoder / branch-unit side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks one in-flight
// response, and buffers returned words in an output register plus one skid entry
// so the decoder can stall without losing data. Redirects flush everything.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    instruction_fetch_unit_if.master       bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        pop;
    logic        req;
    logic [1:0]  occ;
    logic        unused_redirect_lo;

    // Low address bits of a redirect target are discarded.
    assign unused_redirect_lo = |bus.redirect_pc[1:0];

    // Words held or owed after this cycle's transfer; never more than two fit.
    assign pop = out_valid_q && bus.out_ready;
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign req = rst_n && (state_q == RUN) && !bus.redirect_valid && (occ < 2'd2);

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;

    // Control FSM: a redirect always wins, every other state settles into RUN.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = REDIRECT;
        end else begin
            case (state_q)
                IDLE:     state_d = RUN;
                RUN:      state_d = RUN;
                REDIRECT: state_d = RUN;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Fetch address: jump to the word-aligned target on redirect, else step per issued request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (req) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // Output/skid steering: skid drains first, responses fill the front-most free slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.redirect_valid) begin
            // Flush both slots; the in-flight response is ignored by falling through here.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop && skid_valid_q) begin
            out_instr_d = skid_instr_q;
            out_pc_d    = skid_pc_q;
            if (inflight_q) begin
                skid_instr_d = bus.imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || pop) begin
            if (inflight_q) begin
                out_valid_d = 1'b1;
                out_instr_d = bus.imem_rdata;
                out_pc_d    = inflight_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = inflight_pc_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'h0;
            out_pc_q      <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= req;
            inflight_pc_q <= req ? fetch_pc_q : inflight_pc_q;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized
// back-pressure run checked against a sequential-address scoreboard.
module tb_instruction_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    logic rst_n_w;
    logic rst_w_set;

    int checks;
    int errors;

    logic        s_req, s_ov;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        w_req, w_ov;
    logic [31:0] w_addr, w_pc, w_instr;

    instruction_fetch_unit_if bus();
    instruction_fetch_unit_if bus_w();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n_w),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, word = address ^ MAGIC, garbage when idle.
    always @(posedge clk) begin
        bus.imem_rdata   <= bus.imem_req   ? (bus.imem_addr   ^ MAGIC) : $urandom;
        bus_w.imem_rdata <= bus_w.imem_req ? (bus_w.imem_addr ^ MAGIC) : $urandom;
    end

    // One clock cycle: drive inputs after the falling edge, then sample outputs.
    task automatic cycle(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst_n              = rst;
        rst_n_w            = rst_w_set;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_ov    = bus.out_valid;
        s_pc    = bus.out_pc;
        s_instr = bus.out_instr;
        w_req   = bus_w.imem_req;
        w_addr  = bus_w.imem_addr;
        w_ov    = bus_w.out_valid;
        w_pc    = bus_w.out_pc;
        w_instr = bus_w.out_instr;
        if (s_ov && rdy)
            $display("xfer dut  pc=%h instr=%h", s_pc, s_instr);
        if (w_ov && rst_w_set)
            $display("xfer dutw pc=%h instr=%h", w_pc, w_instr);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_req !== 1'b0 || s_ov !== 1'b0 || s_pc !== 32'h0 || s_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got req=%b ov=%b pc=%h instr=%h exp 0 0 0 0", s_req, s_ov, s_pc, s_instr);
        end
    endtask

    task automatic test_basic();
        logic exp_req [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_ov  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ea;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (s_req !== exp_req[c]) begin
                errors++;
                $display("FAIL basic_req c%0d got %b exp %b", c, s_req, exp_req[c]);
            end
            if (exp_req[c]) begin
                ea = 32'(4 * (c - 1));
                checks++;
                if (s_addr !== ea) begin
                    errors++;
                    $display("FAIL basic_addr c%0d got %h exp %h", c, s_addr, ea);
                end
            end
            checks++;
            if (s_ov !== exp_ov[c]) begin
                errors++;
                $display("FAIL basic_ov c%0d got %b exp %b", c, s_ov, exp_ov[c]);
            end
            if (exp_ov[c]) begin
                ea = 32'(4 * (c - 3));
                checks++;
                if (s_pc !== ea || s_instr !== (ea ^ MAGIC)) begin
                    errors++;
                    $display("FAIL basic_word c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, s_pc, s_instr, ea, ea ^ MAGIC);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        int nx;
        logic [31:0] xpc [3];
        int xcyc [3];
        logic rdy;
        nreq = 0;
        nx   = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            rdy = !(c >= 3 && c <= 8);
            cycle(1'b1, rdy, 1'b0, 32'h0);
            if (c <= 8 && s_req) nreq++;
            if (c >= 3 && c <= 8) begin
                checks++;
                if (s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_req_stall c%0d got %b exp 0", c, s_req);
                end
            end
            if (c >= 3 && c <= 8) begin
                checks++;
                if (s_ov !== 1'b1 || s_pc !== 32'h0 || s_instr !== MAGIC) begin
                    errors++;
                    $display("FAIL bp_hold c%0d got ov=%b pc=%h instr=%h exp 1 %h %h", c, s_ov, s_pc, s_instr, 32'h0, MAGIC);
                end
            end
            if (s_ov && rdy && nx < 3) begin
                xpc[nx]  = s_pc;
                xcyc[nx] = c;
                nx++;
            end
        end
        checks++;
        if (nreq != 2) begin
            errors++;
            $display("FAIL bp_buffered got %0d exp 2", nreq);
        end
        checks++;
        if (nx < 3) begin
            errors++;
            $display("FAIL bp_count got %0d exp 3", nx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (xpc[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL bp_order i%0d got %h exp %h", i, xpc[i], 32'(4 * i));
                end
            end
            checks++;
            if (xcyc[0] != 9 || xcyc[1] - xcyc[0] > 2 || xcyc[2] - xcyc[1] > 2) begin
                errors++;
                $display("FAIL bp_gap got cycles %0d %0d %0d exp 9 then gaps <=2", xcyc[0], xcyc[1], xcyc[2]);
            end
        end
    endtask

    task automatic test_redirect();
        logic        got_req, got_x;
        logic [31:0] req_addr, x_pc, x_instr;
        do_reset();
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (s_ov !== 1'b1 || s_pc !== 32'd12) begin
            errors++;
            $display("FAIL rd_pre got ov=%b pc=%h exp 1 %h", s_ov, s_pc, 32'd12);
        end
        // Redirect with both buffers full while the decoder accepts the head word.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_1002);
        checks++;
        if (s_req !== 1'b0 || s_ov !== 1'b1 || s_pc !== 32'd12) begin
            errors++;
            $display("FAIL rd_cycle got req=%b ov=%b pc=%h exp 0 1 %h", s_req, s_ov, s_pc, 32'd12);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_ov !== 1'b0 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL rd_flush got ov=%b req=%b exp 0 0", s_ov, s_req);
        end
        got_req = 1'b0;
        got_x   = 1'b0;
        req_addr = 32'h0;
        x_pc = 32'h0;
        x_instr = 32'h0;
        for (int k = 0; k < 12 && !got_x; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req && !got_req) begin
                got_req  = 1'b1;
                req_addr = s_addr;
            end
            if (s_ov) begin
                got_x   = 1'b1;
                x_pc    = s_pc;
                x_instr = s_instr;
            end
        end
        checks++;
        if (!got_req || req_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rd_req_addr got seen=%b addr=%h exp 1 %h", got_req, req_addr, 32'h0000_1000);
        end
        checks++;
        if (!got_x || x_pc !== 32'h0000_1000 || x_instr !== (32'h0000_1000 ^ MAGIC)) begin
            errors++;
            $display("FAIL rd_first_word got seen=%b pc=%h instr=%h exp 1 %h %h", got_x, x_pc, x_instr, 32'h0000_1000, 32'h0000_1000 ^ MAGIC);
        end
        // Second redirect in a steady stream, squashing a response in flight.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_2003);
        checks++;
        if (s_ov !== 1'b1) begin
            errors++;
            $display("FAIL rd2_pop got ov=%b exp 1", s_ov);
        end
        got_x = 1'b0;
        for (int k = 0; k < 12 && !got_x; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_ov) begin
                got_x   = 1'b1;
                x_pc    = s_pc;
                x_instr = s_instr;
            end
        end
        checks++;
        if (!got_x || x_pc !== 32'h0000_2000 || x_instr !== (32'h0000_2000 ^ MAGIC)) begin
            errors++;
            $display("FAIL rd2_first_word got seen=%b pc=%h instr=%h exp 1 %h %h", got_x, x_pc, x_instr, 32'h0000_2000, 32'h0000_2000 ^ MAGIC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic        got_req;
        logic [31:0] req_addr;
        int nx;
        rst_w_set = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        rst_w_set = 1'b1;
        got_req  = 1'b0;
        req_addr = 32'h0;
        nx = 0;
        for (int k = 0; k < 12 && nx < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (w_req && !got_req) begin
                got_req  = 1'b1;
                req_addr = w_addr;
            end
            if (w_ov) begin
                checks++;
                if (w_pc !== exp_pcs[nx] || w_instr !== (exp_pcs[nx] ^ MAGIC)) begin
                    errors++;
                    $display("FAIL wrap_word i%0d got pc=%h instr=%h exp %h %h", nx, w_pc, w_instr, exp_pcs[nx], exp_pcs[nx] ^ MAGIC);
                end
                nx++;
            end
        end
        checks++;
        if (nx != 3 || !got_req || req_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_progress got words=%0d first_addr=%h exp 3 %h", nx, req_addr, 32'hFFFF_FFF8);
        end
    endtask

    task automatic test_reset_midop();
        logic        got_x;
        logic [31:0] x_pc, x_instr;
        int          req_cyc;
        logic [31:0] req_addr;
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL rm_req_in_reset got %b exp 0", s_req);
        end
        got_x = 1'b0;
        req_cyc = -1;
        req_addr = 32'h0;
        x_pc = 32'h0;
        x_instr = 32'h0;
        for (int c = 0; c < 12 && !got_x; c++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 0) begin
                checks++;
                if (s_ov !== 1'b0 || s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rm_after_edge got ov=%b req=%b exp 0 0", s_ov, s_req);
                end
            end
            if (s_req && req_cyc < 0) begin
                req_cyc  = c;
                req_addr = s_addr;
            end
            if (s_ov) begin
                got_x   = 1'b1;
                x_pc    = s_pc;
                x_instr = s_instr;
            end
        end
        checks++;
        if (req_cyc != 1 || req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_first_req got cycle=%0d addr=%h exp 1 %h", req_cyc, req_addr, 32'h0);
        end
        checks++;
        if (!got_x || x_pc !== 32'h0 || x_instr !== MAGIC) begin
            errors++;
            $display("FAIL rm_first_word got seen=%b pc=%h instr=%h exp 1 %h %h", got_x, x_pc, x_instr, 32'h0, MAGIC);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_req, prev_pc, prev_instr;
        logic        prev_stall, rdy;
        int          issued, delivered;
        exp_pc = 32'h0;
        exp_req = 32'h0;
        prev_pc = 32'h0;
        prev_instr = 32'h0;
        prev_stall = 1'b0;
        issued = 0;
        delivered = 0;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            rdy = 1'($urandom_range(0, 1));
            cycle(1'b1, rdy, 1'b0, 32'h0);
            checks++;
            if (issued - delivered > 2) begin
                errors++;
                $display("FAIL rnd_occ c%0d got %0d exp <=2", c, issued - delivered);
            end
            if (s_req) begin
                checks++;
                if (s_addr !== exp_req) begin
                    errors++;
                    $display("FAIL rnd_req_addr c%0d got %h exp %h", c, s_addr, exp_req);
                end
                exp_req = exp_req + 32'd4;
                issued++;
            end
            if (prev_stall) begin
                checks++;
                if (s_ov !== 1'b1 || s_pc !== prev_pc || s_instr !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_stable c%0d got ov=%b pc=%h instr=%h exp 1 %h %h", c, s_ov, s_pc, s_instr, prev_pc, prev_instr);
                end
            end
            if (s_ov && rdy) begin
                checks++;
                if (s_pc !== exp_pc || s_instr !== (exp_pc ^ MAGIC)) begin
                    errors++;
                    $display("FAIL rnd_word c%0d got pc=%h instr=%h exp %h %h", c, s_pc, s_instr, exp_pc, exp_pc ^ MAGIC);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_stall = s_ov && !rdy;
            prev_pc    = s_pc;
            prev_instr = s_instr;
        end
        checks++;
        if (delivered < 400) begin
            errors++;
            $display("FAIL rnd_progress got %0d exp >=400", delivered);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rst_n_w = 1'b0;
        rst_w_set = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus_w.out_ready = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation timeout");
    end

endmodule
